score_keeper: RTL
=================

Name: score_keeper

Overview:
- Producer side of the scoreboard display interface.
- Consumes per-note hit judgements from the note/judge logic and maintains the statistics the display multiplexes: combo, base_score, bonus_score, acc and level.
- Runs a start/play/finish session FSM.
- Accuracy comes from a multi-cycle serial divider, so acc lags judgements by a bounded latency.

Parameters:
- BONUS_CAP, 100: combo value at which the per-hit bonus stops growing.
- NOTE_W, 16: width of the internal note counter; counter saturates at 2^NOTE_W-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; clears stats and enters PLAY
- finish  in  1  one-cycle pulse; ends the session
- judge_valid  in  1  one-cycle pulse; judgement present
- judge  in  2  0=PERFECT, 1=GREAT, 2=GOOD, 3=MISS
- mod  in  2  0=NONE, 1=HARD, 2=EASY, 3=treated as NONE; sampled per judgement
- difficulty  in  4  chart difficulty 0..15; sampled per judgement
- combo  out  21  current combo
- base_score  out  21  accumulated base score
- bonus_score  out  21  accumulated combo bonus
- acc  out  21  accuracy in hundredths of a percent, 0..10000
- level  out  3  grade, valid in DONE
- busy  out  1  high while a division is running or pending
- done  out  1  high in DONE

Behaviour:
- Reset values (rst_n low, asynchronous): all outputs 0, FSM in IDLE, divider idle.
- FSM states: IDLE, PLAY, DRAIN, GRADE, DONE.
  - IDLE --start--> PLAY
  - PLAY --finish--> DRAIN
  - DRAIN --(divider idle and nothing pending)--> GRADE
  - GRADE --(1 cycle)--> DONE
  - DONE --start--> PLAY
- start in any state: clears combo, scores, acc, level, counters and any pending division; next state PLAY. start has priority over finish in the same cycle.
- judge_valid is honoured only in PLAY, including the cycle finish is asserted (the judgement counts, then DRAIN). Elsewhere it is ignored.
- Judgement update, registered one cycle after judge_valid:
  - Points: PERFECT 30, GREAT 20, GOOD 10, MISS 0.
  - base_score += pts*(difficulty+1).
  - Non-MISS: combo += 1. MISS: combo <= 0.
  - Non-MISS bonus: b = min(new combo, BONUS_CAP); HARD adds b<<1, EASY adds b>>1, otherwise adds b.
  - Accuracy weights: PERFECT 3, GREAT 2, GOOD 1, MISS 0. Weight is added to weight_sum; note_cnt += 1.
- Saturation: combo, base_score and bonus_score saturate at 2097151 and never wrap. note_cnt saturates; weight_sum stops updating once note_cnt saturates.
- Accuracy division:
  - acc = floor(weight_sum*10000 / (note_cnt*3)); 32-bit dividend, restoring division, one quotient bit per cycle.
  - A judgement update launches a division from a snapshot. acc updates 33 cycles after launch.
  - If a judgement arrives while dividing, a pending flag is set. On completion the divider relaunches immediately with the latest snapshot.
  - note_cnt==0: acc stays 0 and no division is launched.
  - busy = dividing OR pending.
- GRADE (computed from final acc):
  - 6 (SS): acc==10000 and zero misses
  - 5 (S): acc>=9500
  - 4 (A): >=9000
  - 3 (B): >=8000
  - 2 (C): >=6000
  - 1 (D): otherwise
  - 0: note_cnt==0
- level reads 0 outside GRADE/DONE. Other outputs hold their values in DONE.
- Asynchronous reset mid-division: abandons the division and returns to IDLE with all values zero.

Optional Feature:
- Macro: SCORE_MAX_COMBO_EN.
- Defined: adds output max_combo[20:0], the highest combo reached this session. It updates on the same cycle as combo, clears on start and reset, and saturates like combo. GRADE 6 additionally requires max_combo == note_cnt.
- Undefined: port and register are absent. Grade rules are exactly as above.

Decomposition:
- Constants.vh holds judge codes, mod codes, point and weight values, the level encodings and the 21-bit stat width macro.
- One sub-module, acc_divider: start/busy/done serial restoring divider with 32-bit dividend and 18-bit divisor.

Test Plan:
- Reset, then start, then 4 PERFECT at difficulty 0, mod NONE -> combo=4, base=120, bonus=1+2+3+4=10; after busy falls, acc=10000.
- PERFECT, PERFECT, MISS, GOOD at difficulty 3 -> combo=1, base=280, bonus=1+2+1=4, acc=floor(7*10000/12)=5833.
- Judgements on consecutive cycles -> busy stays high through the relaunch, and the final acc matches the last snapshot.
- finish after 10 PERFECT -> done high, level=6; repeat with one GREAT among 10 -> acc=9666, level=5.
- Start on the same cycle as finish -> state PLAY and all stats cleared. judge_valid in IDLE/DONE -> no change.
- Drive 2097151 combo-style hits via force/backdoor -> combo holds at 2097151. rst_n pulse mid-division -> all outputs 0 immediately.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// score_keeper_pkg: shared widths, judgement/mod codes, FSM states, grade encodings and helpers.
package score_keeper_pkg;
  localparam int STAT_W = 21;
  localparam logic [STAT_W-1:0] STAT_MAX = 21'h1FFFFF;
  typedef enum logic [1:0] {J_PERFECT, J_GREAT, J_GOOD, J_MISS} judge_e;
  typedef enum logic [1:0] {M_NONE, M_HARD, M_EASY, M_RSVD} mod_e;
  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_DRAIN, S_GRADE, S_DONE} state_e;
  localparam logic [2:0] LV_NONE = 3'd0;
  localparam logic [2:0] LV_D    = 3'd1;
  localparam logic [2:0] LV_C    = 3'd2;
  localparam logic [2:0] LV_B    = 3'd3;
  localparam logic [2:0] LV_A    = 3'd4;
  localparam logic [2:0] LV_S    = 3'd5;
  localparam logic [2:0] LV_SS   = 3'd6;
  function automatic logic [4:0] judge_pts(input logic [1:0] j);
    return j == J_PERFECT ? 5'd30 : j == J_GREAT ? 5'd20 : j == J_GOOD ? 5'd10 : 5'd0;
  endfunction
  // codes are ordered best-to-worst, so the accuracy weight is simply 3 - code
  function automatic logic [1:0] judge_wt(input logic [1:0] j);
    return 2'd3 - j;
  endfunction
  function automatic logic [2:0] grade(input logic [STAT_W-1:0] acc, input logic clean, input logic any);
    return !any ? LV_NONE :
           (acc == 21'd10000 && clean) ? LV_SS :
           acc >= 21'd9500 ? LV_S :
           acc >= 21'd9000 ? LV_A :
           acc >= 21'd8000 ? LV_B :
           acc >= 21'd6000 ? LV_C : LV_D;
  endfunction
endpackage

// File: rtl/score_keeper_if.sv
// score_keeper_if: judgement/control inputs and display statistics of the score keeper.
// SCORE_MAX_COMBO_EN adds the max_combo signal.
interface score_keeper_if;
  import score_keeper_pkg::*;
  logic start, finish, judge_valid;
  logic [1:0] judge, mod;
  logic [3:0] difficulty;
  logic [STAT_W-1:0] combo, base_score, bonus_score, acc;
  logic [2:0] level;
  logic busy, done;
`ifdef SCORE_MAX_COMBO_EN
  logic [STAT_W-1:0] max_combo;
  modport master(output start, finish, judge_valid, judge, mod, difficulty,
                 input combo, base_score, bonus_score, acc, level, busy, done, max_combo);
  modport slave(input start, finish, judge_valid, judge, mod, difficulty,
                output combo, base_score, bonus_score, acc, level, busy, done, max_combo);
`else
  modport master(output start, finish, judge_valid, judge, mod, difficulty,
                 input combo, base_score, bonus_score, acc, level, busy, done);
  modport slave(input start, finish, judge_valid, judge, mod, difficulty,
                output combo, base_score, bonus_score, acc, level, busy, done);
`endif
endinterface

// File: rtl/score_keeper_acc_divider.sv
// score_keeper_acc_divider: restoring divider, 32-bit dividend / 18-bit divisor, one quotient bit per cycle.
module score_keeper_acc_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_start,
  input  logic [31:0] i_dividend,
  input  logic [17:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quot
);
  logic [31:0] r_q;
  logic [17:0] r_rem, r_div;
  logic [5:0]  r_cnt;
  logic        r_busy, r_done;
  logic [18:0] w_sh;
  logic        w_ge;
  assign w_sh = {r_rem, r_q[31]};
  assign w_ge = w_sh >= {1'b0, r_div};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_q <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_q <= i_dividend;
      r_div <= i_divisor;
      r_rem <= '0;
      r_cnt <= 6'd32;
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_q <= {r_q[30:0], w_ge};
        r_rem <= w_ge ? 18'(w_sh - {1'b0, r_div}) : w_sh[17:0];
        r_cnt <= r_cnt - 6'd1;
        r_busy <= r_cnt != 6'd1;
        r_done <= r_cnt == 6'd1;
      end
    end
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_quot = r_q;
endmodule

// File: rtl/score_keeper.sv
// score_keeper: session FSM, saturating judgement statistics and serial accuracy division.
// SCORE_MAX_COMBO_EN adds max_combo tracking and requires an unbroken full combo for SS.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int BONUS_CAP = 100,
  parameter int NOTE_W    = 16
) (
  input logic clk,
  input logic rst_n,
  score_keeper_if.slave bus
);
  localparam int WS_W = NOTE_W + 2;
  state_e r_state, w_nxt;
  logic [STAT_W-1:0] r_combo, r_base, r_bonus, r_acc;
  logic [2:0]        r_level;
  logic [NOTE_W-1:0] r_note, w_note_n;
  logic [WS_W-1:0]   r_wsum, w_wsum_n;
  logic              r_miss, r_pend;
  logic              w_acc_j, w_miss, w_note_sat, w_clean;
  logic [STAT_W-1:0] w_combo_n, w_b, w_badd;
  logic [STAT_W:0]   w_base_sum, w_bon_sum;
  logic [8:0]        w_pinc;
  logic              w_div_busy, w_div_done, w_launch, w_busy;
  logic [31:0]       w_quot, w_dividend;
  logic [17:0]       w_divisor;
  assign w_acc_j    = r_state == S_PLAY && bus.judge_valid && !bus.start;
  assign w_miss     = bus.judge == J_MISS;
  assign w_combo_n  = w_miss ? '0 : r_combo == STAT_MAX ? STAT_MAX : r_combo + 21'd1;
  assign w_pinc     = 9'(judge_pts(bus.judge)) * (9'(bus.difficulty) + 9'd1);
  assign w_base_sum = {1'b0, r_base} + 22'(w_pinc);
  assign w_b        = w_combo_n > 21'(BONUS_CAP) ? 21'(BONUS_CAP) : w_combo_n;
  assign w_badd     = bus.mod == M_HARD ? w_b << 1 : bus.mod == M_EASY ? w_b >> 1 : w_b;
  assign w_bon_sum  = {1'b0, r_bonus} + {1'b0, w_badd};
  assign w_note_sat = &r_note;
  assign w_note_n   = w_note_sat ? r_note : r_note + 1'b1;
  assign w_wsum_n   = w_note_sat ? r_wsum : r_wsum + WS_W'(judge_wt(bus.judge));
  // a fresh judgement launches from its post-update snapshot; a relaunch uses the latest registers
  assign w_launch   = (w_acc_j && !w_div_busy) || (w_div_done && r_pend);
  assign w_dividend = 32'(w_acc_j ? w_wsum_n : r_wsum) * 32'd10000;
  assign w_divisor  = 18'(w_acc_j ? w_note_n : r_note) * 18'd3;
  assign w_busy     = w_div_busy || w_div_done || r_pend;
  score_keeper_acc_divider u_div (
    .clk(clk), .rst_n(rst_n), .i_clr(bus.start), .i_start(w_launch),
    .i_dividend(w_dividend), .i_divisor(w_divisor),
    .o_busy(w_div_busy), .o_done(w_div_done), .o_quot(w_quot)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_nxt;
  always_comb
    w_nxt = bus.start ? S_PLAY :
            (r_state == S_PLAY && bus.finish) ? S_DRAIN :
            (r_state == S_DRAIN && !w_busy) ? S_GRADE :
            r_state == S_GRADE ? S_DONE : r_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || bus.start) begin
      r_combo <= '0;
      r_base <= '0;
      r_bonus <= '0;
      r_acc <= '0;
      r_level <= '0;
      r_note <= '0;
      r_wsum <= '0;
      r_miss <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      if (w_acc_j) begin
        r_combo <= w_combo_n;
        r_base <= w_base_sum[STAT_W] ? STAT_MAX : w_base_sum[STAT_W-1:0];
        r_bonus <= w_bon_sum[STAT_W] ? STAT_MAX : w_bon_sum[STAT_W-1:0];
        r_note <= w_note_n;
        r_wsum <= w_wsum_n;
        r_miss <= r_miss || w_miss;
      end
      if (w_div_done) r_acc <= |w_quot[31:STAT_W] ? STAT_MAX : w_quot[STAT_W-1:0];
      r_pend <= (w_acc_j && w_div_busy) ? 1'b1 : w_div_done ? 1'b0 : r_pend;
      if (r_state == S_GRADE) r_level <= grade(r_acc, w_clean, r_note != '0);
    end
`ifdef SCORE_MAX_COMBO_EN
  logic [STAT_W-1:0] r_max;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || bus.start) r_max <= '0;
    else if (w_acc_j && w_combo_n > r_max) r_max <= w_combo_n;
  assign w_clean = !r_miss && r_max == STAT_W'(r_note);
  assign bus.max_combo = r_max;
`else
  assign w_clean = !r_miss;
`endif
  assign bus.combo       = r_combo;
  assign bus.base_score  = r_base;
  assign bus.bonus_score = r_bonus;
  assign bus.acc         = r_acc;
  assign bus.level       = r_level;
  assign bus.busy        = w_busy;
  assign bus.done        = r_state == S_DONE;
endmodule
